xava_issue_sched: RTL and testbench
===================================

# xava_issue_sched

Issue scheduler between the CV-X-IF coprocessor ports and the AVA accelerator's APU-style request interface. Buffers issued vector instructions with their scalar operands, holds each until the core commits or kills it by ID, dispatches committed instructions in order via an `apu_req`/`apu_gnt` handshake, and returns scalar results (vset-class only) on the X-IF result channel with the correct `id`/`rd`. It replaces the constant `accept`/`result_valid` ties with real sequencing.

## Interface
Parameters:
- `DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `ID_W`, 4: X-IF instruction ID width.

Ports:
- `clk_i` in, 1: clock. All logic is on the rising edge.
- `rst_i` in, 1: asynchronous active-high reset.
- `issue_valid_i` in, 1; `issue_ready_o` out, 1: issue handshake.
- `issue_instr_i` in, 32; `issue_rs0_i`, `issue_rs1_i` in, 32; `issue_id_i` in, ID_W: the issue packet.
- `issue_accept_o` out, 1: instruction accepted. Equals `issue_instr_i[6:0]==7'h57 || issue_instr_i[6:0]==7'h07 || issue_instr_i[6:0]==7'h27` (OP-V/LOAD-FP/STORE-FP).
- `issue_writeback_o` out, 1: `issue_instr_i[6:0]==7'h57 && issue_instr_i[14:12]==3'b111`.
- `commit_valid_i` in, 1; `commit_id_i` in, ID_W; `commit_kill_i` in, 1: commit packet.
- `apu_req_o` out, 1; `apu_gnt_i` in, 1: dispatch handshake.
- `apu_operands_o` out, 96: `{rs1, rs0, instr}` of the head entry.
- `apu_rvalid_i` in, 1; `apu_result_i` in, 32: accelerator completion.
- `result_valid_o` out, 1; `result_ready_i` in, 1: result handshake.
- `result_id_o` out, ID_W; `result_data_o` out, 32; `result_rd_o` out, 5 (`instr[11:7]`); `result_we_o` out, 1 (always 1 when valid).
- `busy_o` out, 1: buffer non-empty or FSM not IDLE.

## Operation
- The buffer is an in-order circular FIFO. Each entry holds instr, rs0, rs1, id, wb, committed, killed. Pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal.
- `issue_ready_o = !full`. A push happens on `issue_valid_i && issue_ready_o && issue_accept_o`. A non-accepted instruction is dropped after its handshake.
- Commit is matched against all valid entries by id (CAM). It sets `committed`, and also sets `killed` if `commit_kill_i`. A commit for an absent id is ignored. A commit whose id equals the id being pushed in the same cycle applies to the new entry.
- Dispatch FSM:
  - IDLE → REQ when the head is valid, committed, and not killed.
  - IDLE pops the head without dispatch when the head is killed (1 cycle per entry).
  - REQ: `apu_req_o=1`, and `apu_operands_o` is held stable. On `apu_gnt_i` → EXEC.
  - EXEC: on `apu_rvalid_i`, if the head has wb set, latch `apu_result_i` and go → RESULT. Otherwise pop and go → IDLE.
  - RESULT: `result_valid_o=1`. On `result_ready_i`, pop and go → IDLE.
- A kill arriving for the head while in REQ/EXEC/RESULT is ignored: the instruction is already dispatched. The core does not do this.
- A push and a pop in the same cycle are both performed. The count is unchanged and accepted when full only if a pop occurs? No: `issue_ready_o` uses the registered full flag, not the same-cycle pop.

## Timing
- Reset values: `issue_ready_o=1`, `apu_req_o=0`, `result_valid_o=0`, `result_data_o=0`, `result_id_o=0`, `result_rd_o=0`, `busy_o=0`, FSM=IDLE, pointers=0, all entries invalid.
- `issue_accept_o`, `issue_writeback_o`, and `result_we_o` are combinational. All other outputs are registered or derived from registered state.
- Minimum latency: issue plus commit in cycle 0 gives the entry visible in cycle 1, and `apu_req_o` in cycle 2.
- Result: `apu_rvalid_i` in cycle n gives `result_valid_o` in cycle n+1, held until ready.
- A reset asserted mid-operation clears all entries and returns to IDLE immediately. No result is emitted for any in-flight instruction.

## Test plan
- Single vsetvli: issue instr=0x0C0572D7, id=3 (cycle 0), commit id=3 kill=0 in the same cycle. Expect `apu_req_o` at cycle 2. Grant at cycle 3 with rvalid result=0x10 at cycle 5 gives `result_valid_o` at cycle 6 with id=3, rd=5, data=0x10.
- Non-writeback vadd (funct3=000), committed. After rvalid, expect no `result_valid_o`, and `busy_o` drops the next cycle.
- Kill: issue ids 1,2,3; commit 2 kill=1, then commit 1 and 3. Expect dispatch of ids 1 and 3 only, in order. Id 2 is popped in IDLE without `apu_req_o`.
- Full: issue 4 entries with no commits. Expect `issue_ready_o=0`. One commit plus completion reasserts ready the cycle after the pop.
- Backpressure: hold `result_ready_i=0` for 5 cycles. Data and id stay stable, and the next committed head is not dispatched until the handshake.
- Out-of-order commit (3 before 1) and reset mid-EXEC. Dispatch order stays 1,2,3. After reset, all outputs return to their reset values and `busy_o=0`.

Source files
------------

// File: rtl/xava_issue_sched.sv
// xava_issue_sched: buffers X-IF issued vector instructions with their scalar
// operands until the core commits or kills them by ID. Committed instructions
// are dispatched in order over the apu_req/apu_gnt handshake. Scalar results
// (vset-class only) are returned on the X-IF result channel.
module xava_issue_sched #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [31:0]     issue_rs0_i,
  input  logic [31:0]     issue_rs1_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            apu_req_o,
  input  logic            apu_gnt_i,
  output logic [95:0]     apu_operands_o,
  input  logic            apu_rvalid_i,
  input  logic [31:0]     apu_result_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [31:0]     result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            busy_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_RESULT} state_t;

  state_t state, state_nxt;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wptr, rptr;
  logic [AW-1:0]    head_idx, tail_idx;
  logic             full, push, pop, latch_res, push_hit;

  // Per-entry control flags (reset) and payload (not reset).
  logic [DEPTH-1:0] ent_vld, ent_cmt, ent_kill, ent_wb;
  logic [31:0]      ent_instr [DEPTH];
  logic [31:0]      ent_rs0   [DEPTH];
  logic [31:0]      ent_rs1   [DEPTH];
  logic [ID_W-1:0]  ent_id    [DEPTH];

  assign head_idx = rptr[AW-1:0];
  assign tail_idx = wptr[AW-1:0];
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign issue_accept_o    = (issue_instr_i[6:0] == 7'h57) ||
                             (issue_instr_i[6:0] == 7'h07) ||
                             (issue_instr_i[6:0] == 7'h27);
  assign issue_writeback_o = (issue_instr_i[6:0] == 7'h57) &&
                             (issue_instr_i[14:12] == 3'b111);
  assign issue_ready_o     = !full;
  assign push              = issue_valid_i && issue_ready_o && issue_accept_o;
  // A commit naming the ID being pushed this cycle lands on the new entry.
  assign push_hit          = commit_valid_i && (commit_id_i == issue_id_i);

  // Operands come straight from the head entry, which cannot move before a pop.
  assign apu_operands_o = {ent_rs1[head_idx], ent_rs0[head_idx], ent_instr[head_idx]};
  assign apu_req_o      = (state == S_REQ);
  assign result_valid_o = (state == S_RESULT);
  assign result_we_o    = result_valid_o;
  assign busy_o         = (wptr != rptr) || (state != S_IDLE);

  // Dispatch FSM next-state, pop and result-latch decisions.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    latch_res = 1'b0;
    case (state)
      S_IDLE: begin
        if (ent_vld[head_idx] && ent_kill[head_idx]) begin
          pop = 1'b1;
        end else if (ent_vld[head_idx] && ent_cmt[head_idx]) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (apu_gnt_i) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (apu_rvalid_i) begin
          if (ent_wb[head_idx]) begin
            latch_res = 1'b1;
            state_nxt = S_RESULT;
          end else begin
            pop       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_RESULT: begin
        if (result_ready_i) begin
          pop       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state and FIFO pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry flags: commit CAM over valid entries, then push, then pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_vld  <= '0;
      ent_cmt  <= '0;
      ent_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && commit_valid_i && (ent_id[i] == commit_id_i)) begin
          ent_cmt[i] <= 1'b1;
          if (commit_kill_i) ent_kill[i] <= 1'b1;
        end
      end
      if (push) begin
        ent_vld[tail_idx]  <= 1'b1;
        ent_cmt[tail_idx]  <= push_hit;
        ent_kill[tail_idx] <= push_hit && commit_kill_i;
      end
      if (pop) ent_vld[head_idx] <= 1'b0;
    end
  end

  // Entry payload capture on push.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_instr[tail_idx] <= issue_instr_i;
      ent_rs0[tail_idx]   <= issue_rs0_i;
      ent_rs1[tail_idx]   <= issue_rs1_i;
      ent_id[tail_idx]    <= issue_id_i;
      ent_wb[tail_idx]    <= issue_writeback_o;
    end
  end

  // Result channel payload, captured when a writeback instruction completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_data_o <= '0;
      result_id_o   <= '0;
      result_rd_o   <= '0;
    end else if (latch_res) begin
      result_data_o <= apu_result_i;
      result_id_o   <= ent_id[head_idx];
      result_rd_o   <= ent_instr[head_idx][11:7];
    end
  end

endmodule

// File: tb/tb_xava_issue_sched.sv
// Directed testbench for xava_issue_sched with hand-computed expectations.
module tb_xava_issue_sched;

  localparam int ID_W = 4;
  localparam logic [31:0] VSET = 32'h0C0572D7;  // OP-V, funct3=111, rd=5
  localparam logic [31:0] VADD = 32'h02000057;  // OP-V, funct3=000

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            issue_valid_i, issue_ready_o;
  logic [31:0]     issue_instr_i, issue_rs0_i, issue_rs1_i;
  logic [ID_W-1:0] issue_id_i;
  logic            issue_accept_o, issue_writeback_o;
  logic            commit_valid_i, commit_kill_i;
  logic [ID_W-1:0] commit_id_i;
  logic            apu_req_o, apu_gnt_i;
  logic [95:0]     apu_operands_o;
  logic            apu_rvalid_i;
  logic [31:0]     apu_result_i;
  logic            result_valid_o, result_ready_i;
  logic [ID_W-1:0] result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o, busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  xava_issue_sched #(.DEPTH(4), .ID_W(ID_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_rs0_i(issue_rs0_i),
    .issue_rs1_i(issue_rs1_i), .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_issue(input logic [31:0] ins, input logic [ID_W-1:0] id,
                          input logic [31:0] rs0);
    issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = id;
    issue_rs0_i = rs0; issue_rs1_i = rs0 + 32'h100;
    cyc();
    issue_valid_i = 1'b0;
  endtask

  task automatic do_commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    cyc();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!apu_req_o && n < 30) begin cyc(); n++; end
    if (!apu_req_o) chk({tag, "_timeout"}, 96'(apu_req_o), 96'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 30) begin cyc(); n++; end
    chk(tag, 96'(busy_o), 96'd0);
  endtask

  // Dispatch and complete the next head; rs0 identifies which entry it was.
  task automatic serve(input string tag, input logic [31:0] exp_rs0, input bit wb,
                       input logic [31:0] res, input logic [ID_W-1:0] exp_id);
    wait_req(tag);
    if (apu_req_o) begin
      chk({tag, "_rs0"}, 96'(apu_operands_o[63:32]), 96'(exp_rs0));
      apu_gnt_i = 1'b1; cyc(); apu_gnt_i = 1'b0;
      chk({tag, "_exec_noreq"}, 96'(apu_req_o), 96'd0);
      apu_rvalid_i = 1'b1; apu_result_i = res; cyc(); apu_rvalid_i = 1'b0;
      chk({tag, "_rv"}, 96'(result_valid_o), 96'(wb));
      if (wb) begin
        chk({tag, "_data"}, 96'(result_data_o), 96'(res));
        chk({tag, "_id"}, 96'(result_id_o), 96'(exp_id));
        result_ready_i = 1'b1; cyc(); result_ready_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 0; issue_instr_i = 0; issue_rs0_i = 0; issue_rs1_i = 0; issue_id_i = 0;
    commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    apu_gnt_i = 0; apu_rvalid_i = 0; apu_result_i = 0; result_ready_i = 0;
    #2;
    chk("rst_ready", 96'(issue_ready_o), 96'd1);
    chk("rst_req", 96'(apu_req_o), 96'd0);
    chk("rst_rv", 96'(result_valid_o), 96'd0);
    chk("rst_data", 96'(result_data_o), 96'd0);
    chk("rst_busy", 96'(busy_o), 96'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    cyc();

    // Decode of accept/writeback with issue_valid low (no push).
    issue_instr_i = 32'h00000027; #1;
    chk("acc_storefp", 96'({issue_accept_o, issue_writeback_o}), 96'b10);
    issue_instr_i = 32'h00000033; #1;
    chk("acc_opint", 96'(issue_accept_o), 96'd0);
    // Non-accepted instruction is dropped.
    do_issue(32'h00000033, 4'd9, 32'h9);
    chk("drop_busy", 96'(busy_o), 96'd0);

    // Single vsetvli: issue + commit in cycle 0.
    issue_valid_i = 1'b1; issue_instr_i = VSET; issue_id_i = 4'd3;
    issue_rs0_i = 32'hAA; issue_rs1_i = 32'hBB;
    commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b0;
    #1;
    chk("v_acc_wb", 96'({issue_accept_o, issue_writeback_o}), 96'b11);
    cyc();  // cycle 1
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    chk("v_c1_req", 96'(apu_req_o), 96'd0);
    chk("v_c1_busy", 96'(busy_o), 96'd1);
    cyc();  // cycle 2
    chk("v_c2_req", 96'(apu_req_o), 96'd1);
    chk("v_c2_ops", apu_operands_o, {32'hBB, 32'hAA, VSET});
    cyc();  // cycle 3
    apu_gnt_i = 1'b1;
    chk("v_c3_req", 96'(apu_req_o), 96'd1);
    cyc();  // cycle 4
    apu_gnt_i = 1'b0;
    chk("v_c4_req", 96'(apu_req_o), 96'd0);
    cyc();  // cycle 5
    apu_rvalid_i = 1'b1; apu_result_i = 32'h10;
    chk("v_c5_rv", 96'(result_valid_o), 96'd0);
    cyc();  // cycle 6
    apu_rvalid_i = 1'b0; result_ready_i = 1'b1;
    chk("v_c6_rv", 96'(result_valid_o), 96'd1);
    chk("v_c6_res", 96'({result_id_o, result_rd_o, result_data_o, result_we_o}),
        96'({4'd3, 5'd5, 32'h10, 1'b1}));
    cyc();  // cycle 7
    result_ready_i = 1'b0;
    chk("v_c7_rv", 96'(result_valid_o), 96'd0);
    chk("v_c7_busy", 96'(busy_o), 96'd0);

    // Non-writeback vadd: no result, busy drops the cycle after rvalid.
    issue_valid_i = 1'b1; issue_instr_i = VADD; issue_id_i = 4'd5;
    issue_rs0_i = 32'h5; issue_rs1_i = 32'h6;
    commit_valid_i = 1'b1; commit_id_i = 4'd5;
    #1;
    chk("a_wb", 96'(issue_writeback_o), 96'd0);
    cyc(); issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    cyc();
    chk("a_req", 96'(apu_req_o), 96'd1);
    apu_gnt_i = 1'b1; cyc(); apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1; apu_result_i = 32'hDEAD; #1;
    chk("a_exec_busy", 96'(busy_o), 96'd1);
    cyc(); apu_rvalid_i = 1'b0;
    chk("a_rv", 96'(result_valid_o), 96'd0);
    chk("a_busy", 96'(busy_o), 96'd0);

    // Kill: ids 1,2,3; id 2 killed and skipped.
    do_issue(VADD, 4'd1, 32'd1);
    do_issue(VADD, 4'd2, 32'd2);
    do_issue(VADD, 4'd3, 32'd3);
    do_commit(4'd2, 1'b1);
    do_commit(4'd1, 1'b0);
    do_commit(4'd3, 1'b0);
    serve("k_1", 32'd1, 1'b0, 32'h0, 4'd1);
    serve("k_3", 32'd3, 1'b0, 32'h0, 4'd3);
    wait_idle("k_idle");

    // Full: four entries without commits.
    for (int k = 0; k < 4; k++) do_issue(VADD, 4'(4 + k), 32'(40 + k));
    chk("f_ready0", 96'(issue_ready_o), 96'd0);
    do_issue(VADD, 4'd12, 32'd99);  // refused while full
    chk("f_ready0b", 96'(issue_ready_o), 96'd0);
    do_commit(4'd4, 1'b0);
    wait_req("f_4");
    chk("f_rs0", 96'(apu_operands_o[63:32]), 96'd40);
    apu_gnt_i = 1'b1; cyc(); apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1; #1;
    chk("f_ready_prepop", 96'(issue_ready_o), 96'd0);
    cyc(); apu_rvalid_i = 1'b0;
    chk("f_ready_after", 96'(issue_ready_o), 96'd1);
    do_commit(4'd5, 1'b1);
    do_commit(4'd6, 1'b1);
    do_commit(4'd7, 1'b1);
    wait_idle("f_idle");

    // Backpressure on the result channel.
    do_issue(VSET, 4'd8, 32'd8);
    do_issue(VSET, 4'd9, 32'd9);
    do_commit(4'd8, 1'b0);
    do_commit(4'd9, 1'b0);
    wait_req("b_8");
    apu_gnt_i = 1'b1; cyc(); apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b1; apu_result_i = 32'h55; cyc(); apu_rvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("b_hold", 96'({result_valid_o, result_id_o, result_data_o, apu_req_o}),
          96'({1'b1, 4'd8, 32'h55, 1'b0}));
      cyc();
    end
    result_ready_i = 1'b1; cyc(); result_ready_i = 1'b0;
    serve("b_9", 32'd9, 1'b1, 32'h66, 4'd9);
    wait_idle("b_idle");

    // Out-of-order commit: dispatch stays in issue order.
    do_issue(VADD, 4'd1, 32'd11);
    do_issue(VADD, 4'd2, 32'd12);
    do_issue(VADD, 4'd3, 32'd13);
    do_commit(4'd3, 1'b0);
    cyc();
    chk("o_noreq", 96'(apu_req_o), 96'd0);
    do_commit(4'd1, 1'b0);
    do_commit(4'd2, 1'b0);
    serve("o_1", 32'd11, 1'b0, 32'h0, 4'd1);
    serve("o_2", 32'd12, 1'b0, 32'h0, 4'd2);
    serve("o_3", 32'd13, 1'b0, 32'h0, 4'd3);

    // Reset mid-EXEC with a writeback instruction in flight.
    do_issue(VSET, 4'd4, 32'd14);
    do_issue(VADD, 4'd5, 32'd15);
    do_commit(4'd4, 1'b0);
    wait_req("r_4");
    apu_gnt_i = 1'b1; cyc(); apu_gnt_i = 1'b0;
    rst_i = 1'b1; #1;
    chk("r_async", 96'({issue_ready_o, apu_req_o, result_valid_o, busy_o}), 96'b1000);
    chk("r_res", 96'({result_data_o, result_id_o, result_rd_o}), 96'd0);
    cyc();
    rst_i = 1'b0;
    apu_rvalid_i = 1'b1; apu_result_i = 32'h77; cyc(); apu_rvalid_i = 1'b0;
    chk("r_norv", 96'({result_valid_o, busy_o, apu_req_o}), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
